// File: rtl/exe_stage.sv
// exe_stage: execute stage with operand forwarding, Val2 shifter, ALU, NZCV register,
// branch-target adder and a 32-step shift-add multiplier. Revision 1.0
`default_nettype none

module exe_stage #(
   parameter logic [3:0] MUL_CMD  = 4'b1010,
   parameter logic [3:0] SR_RESET = 4'b0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sram_freeze,
   input  logic        wb_en_in,
   input  logic        mem_r_en_in,
   input  logic        mem_w_en_in,
   input  logic        B_in,
   input  logic        S_in,
   input  logic [31:0] PC_in,
   input  logic [3:0]  exe_cmd_in,
   input  logic [31:0] Val_Rn_in,
   input  logic [31:0] Val_Rm_in,
   input  logic        imm_in,
   input  logic [11:0] shift_operand_in,
   input  logic [23:0] signed_imm_24_in,
   input  logic [3:0]  Dest_in,
   input  logic [1:0]  sel_src1,
   input  logic [1:0]  sel_src2,
   input  logic [31:0] mem_alu_res,
   input  logic [31:0] wb_value,
   output logic [31:0] alu_result,
   output logic [31:0] br_addr,
   output logic [31:0] st_val,
   output logic [3:0]  status,
   output logic        wb_en,
   output logic        mem_r_en,
   output logic        mem_w_en,
   output logic        B,
   output logic [3:0]  Dest,
   output logic        mul_stall
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } mul_state_e;

   mul_state_e  state_q;
   logic [4:0]  cnt_q;
   logic [31:0] prod_q, mcand_q, mplier_q;
   logic [3:0]  status_q, status_d;

   logic [31:0] op_a, rm_fwd, val2, alu_res, b_op;
   logic [32:0] sum;
   logic        cin, cout, vout, arith, mul_start, status_we;

   function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
      ror32 = (x >> n) | (x << (6'd32 - {1'b0, n}));
   endfunction

   always_comb begin
      case (sel_src1)
         2'b01:   op_a = mem_alu_res;
         2'b10:   op_a = wb_value;
         default: op_a = Val_Rn_in;
      endcase
      case (sel_src2)
         2'b01:   rm_fwd = mem_alu_res;
         2'b10:   rm_fwd = wb_value;
         default: rm_fwd = Val_Rm_in;
      endcase
   end

   always_comb begin
      if (mem_r_en_in || mem_w_en_in) begin
         val2 = {20'b0, shift_operand_in};
      end else if (imm_in) begin
         val2 = ror32({24'b0, shift_operand_in[7:0]}, {shift_operand_in[11:8], 1'b0});
      end else begin
         case (shift_operand_in[6:5])
            2'b00:   val2 = rm_fwd << shift_operand_in[11:7];
            2'b01:   val2 = rm_fwd >> shift_operand_in[11:7];
            2'b10:   val2 = $signed(rm_fwd) >>> shift_operand_in[11:7];
            default: val2 = ror32(rm_fwd, shift_operand_in[11:7]);
         endcase
      end
   end

   // Subtraction runs through the same adder as A + ~Val2 + carry-in, so C is NOT borrow.
   always_comb begin
      arith = 1'b0;
      b_op  = val2;
      cin   = 1'b0;
      case (exe_cmd_in)
         4'b0010: arith = 1'b1;
         4'b0011: begin arith = 1'b1; cin = status_q[1]; end
         4'b0100: begin arith = 1'b1; b_op = ~val2; cin = 1'b1; end
         4'b0101: begin arith = 1'b1; b_op = ~val2; cin = status_q[1]; end
         default: ;
      endcase
      sum  = {1'b0, op_a} + {1'b0, b_op} + {32'b0, cin};
      cout = sum[32];
      vout = (op_a[31] == b_op[31]) && (sum[31] != op_a[31]);
      case (exe_cmd_in)
         4'b0001: alu_res = val2;
         4'b1001: alu_res = ~val2;
         4'b0010, 4'b0011, 4'b0100, 4'b0101: alu_res = sum[31:0];
         4'b0110: alu_res = op_a & val2;
         4'b0111: alu_res = op_a | val2;
         4'b1000: alu_res = op_a ^ val2;
         default: alu_res = 32'b0;
      endcase
   end

   // Reset gates the start so the stall is low while rst is asserted.
   assign mul_start = rst && (state_q == S_IDLE) && (exe_cmd_in == MUL_CMD) && wb_en_in;
   assign mul_stall = mul_start || (state_q == S_BUSY);

   assign alu_result = ((state_q == S_DONE) || (exe_cmd_in == MUL_CMD)) ? prod_q : alu_res;

   assign status_we = S_in && !mul_stall;
   assign status_d  = {alu_result[31], (alu_result == 32'b0),
                       (arith && state_q != S_DONE) ? cout : status_q[1],
                       (arith && state_q != S_DONE) ? vout : status_q[0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 5'd0;
         prod_q   <= 32'b0;
         mcand_q  <= 32'b0;
         mplier_q <= 32'b0;
         status_q <= SR_RESET;
      end else if (!sram_freeze) begin
         if (status_we) status_q <= status_d;
         case (state_q)
            S_IDLE: begin
               if (mul_start) begin
                  mcand_q  <= op_a;
                  mplier_q <= rm_fwd;
                  prod_q   <= 32'b0;
                  cnt_q    <= 5'd0;
                  state_q  <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (mplier_q[0]) prod_q <= prod_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_q <= S_DONE;
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign status   = status_q;
   assign st_val   = rm_fwd;
   assign br_addr  = PC_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};
   assign wb_en    = wb_en_in    && !mul_stall;
   assign mem_r_en = mem_r_en_in && !mul_stall;
   assign mem_w_en = mem_w_en_in && !mul_stall;
   assign B        = B_in        && !mul_stall;
   assign Dest     = Dest_in;

endmodule

`default_nettype wire

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed stimulus for exe_stage checked against an arithmetic reference model.
`default_nettype none

module tb_exe_stage;
   localparam logic [3:0] MUL = 4'b1010;
   localparam logic [3:0] MOV = 4'b0001, MVN = 4'b1001, ADD = 4'b0010, ADC = 4'b0011,
                          SUB = 4'b0100, SBC = 4'b0101, AND = 4'b0110, ORR = 4'b0111,
                          EOR = 4'b1000;

   logic        clk = 1'b0, rst = 1'b0;
   logic        sram_freeze, wb_en_in, mem_r_en_in, mem_w_en_in, B_in, S_in, imm_in;
   logic [31:0] PC_in, Val_Rn_in, Val_Rm_in, mem_alu_res, wb_value;
   logic [3:0]  exe_cmd_in, Dest_in;
   logic [11:0] shift_operand_in;
   logic [23:0] signed_imm_24_in;
   logic [1:0]  sel_src1, sel_src2;
   logic [31:0] alu_result, br_addr, st_val;
   logic [3:0]  status, Dest;
   logic        wb_en, mem_r_en, mem_w_en, B, mul_stall;

   int n_checks = 0;
   int n_fail   = 0;

   exe_stage #(.MUL_CMD(MUL), .SR_RESET(4'b0000)) dut (
      .clk(clk), .rst(rst), .sram_freeze(sram_freeze),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .B_in(B_in), .S_in(S_in), .PC_in(PC_in), .exe_cmd_in(exe_cmd_in),
      .Val_Rn_in(Val_Rn_in), .Val_Rm_in(Val_Rm_in), .imm_in(imm_in),
      .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
      .Dest_in(Dest_in), .sel_src1(sel_src1), .sel_src2(sel_src2),
      .mem_alu_res(mem_alu_res), .wb_value(wb_value),
      .alu_result(alu_result), .br_addr(br_addr), .st_val(st_val), .status(status),
      .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .B(B), .Dest(Dest),
      .mul_stall(mul_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [3:0]  m_status = 4'b0000;
   int          m_phase  = 0;   // 0 idle, 1 multiplying, 2 result presented
   int          m_left   = 0;
   logic [31:0] m_prod   = 32'b0;

   function automatic logic [31:0] f_fwd(input logic [1:0] s, input logic [31:0] r);
      if (s == 2'b01) return mem_alu_res;
      if (s == 2'b10) return wb_value;
      return r;
   endfunction

   function automatic logic [31:0] f_rotr(input logic [31:0] x, input int n);
      logic [31:0] r = x;
      for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
      return r;
   endfunction

   function automatic logic [31:0] f_val2();
      logic [31:0] x;
      int n;
      if (mem_r_en_in || mem_w_en_in) return {20'b0, shift_operand_in};
      if (imm_in) return f_rotr({24'b0, shift_operand_in[7:0]}, 2 * int'(shift_operand_in[11:8]));
      n = int'(shift_operand_in[11:7]);
      x = f_fwd(sel_src2, Val_Rm_in);
      case (shift_operand_in[6:5])
         2'b00: return x << n;
         2'b01: return x >> n;
         2'b10: begin
            for (int i = 0; i < n; i++) x = {x[31], x[31:1]};
            return x;
         end
         default: return f_rotr(x, n);
      endcase
   endfunction

   // returns {arith, C, V, result}
   function automatic logic [34:0] f_alu(input logic [3:0] cmd, input logic [31:0] a,
                                         input logic [31:0] b, input logic cin_l);
      longint ua, ub, sa, sb, ur, sr;
      int ci;
      logic c, v, ar;
      ua = {32'b0, a}; ub = {32'b0, b};
      sa = $signed(a); sb = $signed(b);
      ci = cin_l ? 1 : 0;
      ur = 0; sr = 0; c = m_status[1]; v = m_status[0]; ar = 1'b1;
      case (cmd)
         ADD: begin ur = ua + ub;      sr = sa + sb;      c = (ur > 64'hFFFFFFFF); end
         ADC: begin ur = ua + ub + ci; sr = sa + sb + ci; c = (ur > 64'hFFFFFFFF); end
         SUB: begin ur = ua - ub;      sr = sa - sb;      c = (ua >= ub); end
         SBC: begin ur = ua - ub - (1 - ci); sr = sa - sb - (1 - ci); c = (ua >= ub + (1 - ci)); end
         MOV: begin ar = 1'b0; ur = ub; end
         MVN: begin ar = 1'b0; ur = {32'b0, ~b}; end
         AND: begin ar = 1'b0; ur = {32'b0, a & b}; end
         ORR: begin ar = 1'b0; ur = {32'b0, a | b}; end
         EOR: begin ar = 1'b0; ur = {32'b0, a ^ b}; end
         default: ar = 1'b0;
      endcase
      if (ar) v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      return {ar, c, v, ur[31:0]};
   endfunction

   function automatic logic f_stall();
      return rst && ((m_phase == 0 && exe_cmd_in == MUL && wb_en_in) || m_phase == 1);
   endfunction

   function automatic logic [34:0] f_exp();
      logic [34:0] r;
      r = f_alu(exe_cmd_in, f_fwd(sel_src1, Val_Rn_in), f_val2(), m_status[1]);
      if (m_phase == 2 || exe_cmd_in == MUL) r = {3'b000, m_prod};
      return r;
   endfunction

   function automatic logic [3:0] f_new_status();
      logic [34:0] r = f_exp();
      return {r[31], r[31:0] == 32'b0, r[34] ? r[33] : m_status[1], r[34] ? r[32] : m_status[0]};
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_status <= 4'b0000;
         m_phase  <= 0;
         m_left   <= 0;
         m_prod   <= 32'b0;
      end else begin
         if (S_in && !sram_freeze && !f_stall()) m_status <= f_new_status();
         if (!sram_freeze) begin
            case (m_phase)
               0: if (f_stall()) begin
                     m_phase <= 1;
                     m_left  <= 32;
                     m_prod  <= f_fwd(sel_src1, Val_Rn_in) * f_fwd(sel_src2, Val_Rm_in);
                  end
               1: begin
                     if (m_left == 1) m_phase <= 2;
                     m_left <= m_left - 1;
                  end
               default: m_phase <= 0;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      logic [34:0] e;
      logic        st;
      longint      t;
      e  = f_exp();
      st = f_stall();
      t  = {32'b0, PC_in} + 4 * longint'($signed(signed_imm_24_in));
      chk("mul_stall", {31'b0, mul_stall}, {31'b0, st});
      chk("status", {28'b0, status}, {28'b0, m_status});
      chk("br_addr", br_addr, t[31:0]);
      chk("st_val", st_val, f_fwd(sel_src2, Val_Rm_in));
      chk("dest", {28'b0, Dest}, {28'b0, Dest_in});
      chk("ctl", {28'b0, wb_en, mem_r_en, mem_w_en, B},
          st ? 32'b0 : {28'b0, wb_en_in, mem_r_en_in, mem_w_en_in, B_in});
      if (!st) chk("alu_result", alu_result, e[31:0]);
   end

   // ---------------- stimulus ----------------
   typedef struct packed {
      logic [3:0]  cmd;
      logic        s;
      logic [31:0] rn;
      logic [31:0] rm;
      logic        imm;
      logic [11:0] sh;
      logic        mr;
      logic        mw;
      logic [1:0]  s1;
      logic [1:0]  s2;
      logic        frz;
   } vec_t;

   vec_t vecs [12];

   task automatic nop();
      sram_freeze = 0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; B_in = 0; S_in = 0;
      exe_cmd_in = MOV; imm_in = 1; shift_operand_in = 12'h000; sel_src1 = 0; sel_src2 = 0;
      Val_Rn_in = 0; Val_Rm_in = 0; Dest_in = 4'h3;
   endtask

   task automatic drive(input logic [3:0] cmd, input logic s, input logic [31:0] rn,
                        input logic [31:0] rm, input logic imm, input logic [11:0] sh);
      exe_cmd_in = cmd; S_in = s; Val_Rn_in = rn; Val_Rm_in = rm; imm_in = imm;
      shift_operand_in = sh;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_mul(output int cnt);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!mul_stall) return;
         cnt++;
         chk("mul_bubble_wb_en", {31'b0, wb_en}, 32'd0);
      end
      chk("mul_timeout", {31'b0, mul_stall}, 32'd0);
   endtask

   initial begin
      int cnt;
      nop();
      PC_in = 32'h0000_0100; signed_imm_24_in = 24'h000010;
      mem_alu_res = 32'h10; wb_value = 32'h2;
      vecs[0]  = '{ADD, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1, 12'h001, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
      vecs[1]  = '{ADC, 1'b1, 32'h10,       32'h0,        1'b1, 12'h005, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
      vecs[2]  = '{SBC, 1'b1, 32'h5,        32'h0,        1'b1, 12'h005, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
      vecs[3]  = '{AND, 1'b1, 32'hF0F0,     32'h0FF0,     1'b0, 12'h000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
      vecs[4]  = '{ORR, 1'b0, 32'h1,        32'h1,        1'b0, 12'h200, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
      vecs[5]  = '{EOR, 1'b1, 32'hFFFF0000, 32'h0000FFFF, 1'b0, 12'h420, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
      vecs[6]  = '{MVN, 1'b1, 32'h0,        32'h0,        1'b1, 12'h0FF, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
      vecs[7]  = '{MOV, 1'b0, 32'h0,        32'h12345678, 1'b0, 12'h260, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
      vecs[8]  = '{ADD, 1'b0, 32'h1000,     32'h77,       1'b0, 12'hABC, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0};
      vecs[9]  = '{SUB, 1'b1, 32'h1,        32'h99,       1'b0, 12'h000, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0};
      vecs[10] = '{ADD, 1'b1, 32'h0,        32'h0,        1'b1, 12'h000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1};
      vecs[11] = '{ORR, 1'b1, 32'h5,        32'h0,        1'b1, 12'h00A, 1'b0, 1'b0, 2'd3, 2'd1, 1'b0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_status", {28'b0, status}, 32'd0);
      chk("reset_stall", {31'b0, mul_stall}, 32'd0);
      step(); rst = 1;

      drive(ADD, 1, 32'h7FFFFFFF, 0, 1, 12'h001);
      @(negedge clk); chk("add_ovf_res", alu_result, 32'h80000000);
      step(); S_in = 0;
      @(negedge clk); chk("add_ovf_flags", {28'b0, status}, 32'h9);

      step(); drive(SUB, 1, 32'h5, 0, 1, 12'h005);
      @(negedge clk); chk("sub_zero_res", alu_result, 32'h0);
      step(); drive(SUB, 0, 32'h3, 0, 1, 12'h005);
      @(negedge clk); chk("sub_zero_flags", {28'b0, status}, 32'h6);
      step();
      @(negedge clk); chk("sub_s0_hold", {28'b0, status}, 32'h6);

      step(); drive(MOV, 0, 0, 0, 1, 12'h4FF);
      @(negedge clk); chk("mov_imm_rot", alu_result, 32'hFF000000);
      step(); drive(MOV, 0, 0, 32'h80000000, 0, 12'h240);
      @(negedge clk); chk("mov_asr4", alu_result, 32'hF8000000);
      step(); drive(ADD, 0, 32'h999, 0, 1, 12'h001); sel_src1 = 2'b01;
      @(negedge clk); chk("fwd_mem_add", alu_result, 32'h11);
      step(); sel_src1 = 2'b00; signed_imm_24_in = 24'hFFFFFE; B_in = 1;
      @(negedge clk); chk("br_addr_neg", br_addr, 32'hF8);
      step(); B_in = 0;

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].cmd, vecs[i].s, vecs[i].rn, vecs[i].rm, vecs[i].imm, vecs[i].sh);
         mem_r_en_in = vecs[i].mr; mem_w_en_in = vecs[i].mw;
         sel_src1 = vecs[i].s1; sel_src2 = vecs[i].s2; sram_freeze = vecs[i].frz;
         wb_en_in = i[0]; B_in = i[1]; Dest_in = 4'(i);
         step();
      end
      nop();

      // multiply with flags: 0xFFFF * 0x10001
      drive(MUL, 1, 32'h0000FFFF, 32'h00010001, 0, 12'h000); wb_en_in = 1;
      wait_mul(cnt);
      chk("mul_stall_cycles", cnt, 32'd33);
      chk("mul_done_res", alu_result, 32'hFFFFFFFF);
      chk("mul_done_wb_en", {31'b0, wb_en}, 32'd1);
      step(); nop();
      @(negedge clk); chk("mul_nz", {30'b0, status[3:2]}, 32'h2);

      // reset while multiplying, counter at 10
      step(); drive(MUL, 0, 32'h3, 32'h5, 0, 12'h000); wb_en_in = 1;
      repeat (11) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_mid_stall", {31'b0, mul_stall}, 32'd0);
      chk("rst_mid_status", {28'b0, status}, 32'd0);
      step(); nop(); rst = 1;

      // freeze while the result is presented
      step(); drive(MUL, 0, 32'h3, 32'h7, 0, 12'h000); wb_en_in = 1;
      wait_mul(cnt);
      chk("mul2_res", alu_result, 32'd21);
      #1 sram_freeze = 1;
      repeat (3) begin
         @(negedge clk);
         chk("frz_done_res", alu_result, 32'd21);
         chk("frz_done_stall", {31'b0, mul_stall}, 32'd0);
      end
      step(); sram_freeze = 0;
      step(); nop();
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
